cordic_result_fifo: RTL

//  Downstream stage of cordic_proc. Captures each result the coprocessor presents
//  (x_o, y_o, phi_o, quart, qualified by data_ready) and buffers it in a small FIFO.

---
 rtl/cordic_result_fifo.sv | 133 +++++++++++++
 1 files changed

// File: rtl/cordic_result_fifo.sv
// cordic_result_fifo
// Buffers cordic_proc results in a small first-word-fall-through FIFO.
// Each rising edge of data_ready captures one result {quart, phi, y, x}.
// Results leave on a valid/ready stream.
// cp_enable throttles the coprocessor when the FIFO is nearly full.
// A result that arrives while the FIFO is full and not draining is dropped,
// and the sticky overflow flag records the loss.
module cordic_result_fifo #(
    parameter int DATA_WIDTH = 20,
    parameter int PHI_WIDTH  = 22,
    parameter int DEPTH      = 4,
    parameter int AFULL_LVL  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable_i,
    output logic                         cp_enable,
    input  logic                         data_ready,
    input  logic [DATA_WIDTH-1:0]        x_o,
    input  logic [DATA_WIDTH-1:0]        y_o,
    input  logic [PHI_WIDTH-1:0]         phi_o,
    input  logic [1:0]                   quart,
    input  logic                         flush,
    input  logic                         ovf_clr,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH-1:0]        m_x,
    output logic [DATA_WIDTH-1:0]        m_y,
    output logic [PHI_WIDTH-1:0]         m_phi,
    output logic [1:0]                   m_quart,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 2 + PHI_WIDTH + 2 * DATA_WIDTH;

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LVL);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_dr_q;
    logic               r_overflow;

    logic               w_cap;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [ENTRY_W-1:0] w_wr_entry;
    logic [ENTRY_W-1:0] w_head;

    // A held data_ready level yields a single capture on its rising edge.
    assign w_cap  = data_ready & ~r_dr_q;
    assign w_full = (r_count == FULL_CNT);
    assign w_pop  = m_valid & m_ready & ~flush;

    // A simultaneous pop frees the slot, so a capture at full is still accepted.
    assign w_push = w_cap & (~w_full | (m_valid & m_ready)) & ~flush;
    assign w_drop = w_cap & w_full & ~(m_valid & m_ready) & ~flush;

    assign w_wr_entry = {quart, phi_o, y_o, x_o};

    // Head fields are forced to zero while empty, so unreset storage never leaks out.
    assign m_valid = (r_count != '0);
    assign w_head  = m_valid ? r_mem[r_rd_ptr] : '0;
    assign {m_quart, m_phi, m_y, m_x} = w_head;

    assign count     = r_count;
    assign overflow  = r_overflow;
    assign cp_enable = enable_i & (r_count < AFULL_CNT);

    // Delay flop for data_ready edge detection; it runs through flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state always uses non-blocking assignments, so every
            // flop samples the pre-edge values regardless of process ordering.
            r_dr_q <= 1'b0;
        end else begin
            r_dr_q <= data_ready;
        end
    end

    // Read/write pointers and occupancy count. Flush overrides push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage, written at the tail on each accepted push.
    // NOTE: the storage array has no reset. The count alone decides validity,
    // which keeps the array free of reset wiring.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // Sticky overflow flag. A new drop wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

endmodule
